mcdt_arbiter: RTL
=================

# mcdt_arbiter

Round-robin burst arbiter that shares the single MCDT output port among the three channel FIFOs. It sits between the per-channel FIFOs (head data plus non-empty flag) and the formatter/output stage. It pops at most one word per cycle from the granted channel and presents it on a registered `mcdt_data_o`/`mcdt_val_o`/`mcdt_id_o` bus. Grants are held for up to `BURST_MAX` words, then rotate fairly.

## Interface
- `DW`, default 32: data width of each channel and of the output.
- `BURST_MAX`, default 4: maximum words popped per grant. Legal range is 1..16.

Clock, reset and ports:
- Clock is `clk_i`, reset is `rstn_i`. One clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock.
- `rstn_i` in 1: asynchronous active-low reset.
- `ch0_req_i`, `ch1_req_i`, `ch2_req_i` in 1 each: channel FIFO non-empty.
- `ch0_data_i`, `ch1_data_i`, `ch2_data_i` in DW each: FIFO head word, valid whenever the matching req is high.
- `arb_en_i` in 3: per-channel enable mask; bit N gates channel N.
- `ch0_pop_o`, `ch1_pop_o`, `ch2_pop_o` out 1 each: combinational pop; the FIFO advances at the clock edge.
- `mcdt_data_o` out DW: registered output word.
- `mcdt_val_o` out 1: registered output valid.
- `mcdt_id_o` out 2: registered source channel of `mcdt_data_o`.

## Operation
- **State register:** two states, IDLE and XFER.
  - `owner` (2 bits) is the current grant.
  - `last_id` (2 bits) is the previous grant.
  - `cnt` (`$clog2(BURST_MAX)`+1 bits) counts words popped in the current burst.
- **Eligibility:** channel N is eligible when `chN_req_i & arb_en_i[N]`.
- **IDLE:**
  - If any channel is eligible, choose the first eligible channel in cyclic order starting at `last_id`+1 (wrapping 2→0).
  - Load `owner` with it, clear `cnt`, go to XFER.
  - No pop happens in an IDLE cycle.
- **XFER, pop rule:**
  - `chN_pop_o` = (state==XFER) & (owner==N) & `chN_req_i` & `arb_en_i[N]`.
  - At most one pop is high in any cycle.
- **XFER, pop cycle:**
  - Register `mcdt_data_o`=head data, `mcdt_val_o`=1, `mcdt_id_o`=owner.
  - Increment `cnt`.
  - If `cnt`==BURST_MAX-1, set `last_id`=owner and go to IDLE.
- **XFER, no pop** (owner req low or owner disabled):
  - Set `last_id`=owner and go to IDLE.
  - Register `mcdt_val_o`=0 and `mcdt_data_o`=0.
- **Output idle values:** any cycle without a pop registers `mcdt_val_o`=0 and `mcdt_data_o`=0. `mcdt_id_o` holds its last value.
- **Gaps and ordering:**
  - Each grant change costs exactly one IDLE bubble cycle.
  - A burst that ends by reaching `BURST_MAX` is always followed by IDLE, even if the owner still requests. This lets the other channels compete.
  - A channel that is the only eligible requester is re-granted after that bubble.
  - An enable bit deasserting mid-burst ends the burst in that same cycle, with no pop.

## Timing
- **Reset values:**
  - state=IDLE, `owner`=0, `last_id`=2, so ch0 wins the first arbitration, `cnt`=0.
  - `mcdt_data_o`=0, `mcdt_val_o`=0, `mcdt_id_o`=0.
  - All pops are 0, which follows combinationally from IDLE.
- **Latency:**
  - Req rises in cycle n with the arbiter in IDLE.
  - The grant is latched at edge n+1.
  - The pop is high in cycle n+1.
  - Data is valid on `mcdt_*` after edge n+2.
  - Request to output: 2 cycles.
- **Throughput:** BURST_MAX words per BURST_MAX+1 cycles under full load.
- **Reset mid-burst:** outputs clear immediately (asynchronous). The burst is discarded. The first grant after release goes to ch0.
- **Simultaneous requests:** resolved only by the rotation from `last_id`, never by fixed priority.

## Structure
- **Shared package `mcdt_pkg`:**
  - `mcdt_arb_state_e` enum {IDLE, XFER}.
  - `MCDT_NCH`=3.
  - `MCDT_ID_W`=2.
- **Sub-module `mcdt_rr_pick`:** combinational. Inputs are an eligible mask[2:0] and `last_id`. Outputs are `found` and `next_id`. It is reusable and unit-testable on its own.
- **Top:** `mcdt_arbiter` holds the state register, the burst counter, the pop decode and the output registers.

## Test plan
1. **Single channel, short:** ch0 req high for exactly 3 pops with data C0_0000..C0_0002, enable=3'b111.
   - Pops in 3 consecutive cycles.
   - `mcdt_val_o` high for 3 cycles, id=0, data in order, starting 2 cycles after req.
2. **Full load:** all three channels always requesting, BURST_MAX=4.
   - Output ids: 0,0,0,0, bubble, 1×4, bubble, 2×4, bubble, 0…
   - Each channel gets exactly 4 words per 15 cycles.
3. **Enable mask:** all requesting, `arb_en_i`=3'b101.
   - ch1_pop never asserts.
   - Ids alternate 0×4 / 2×4.
4. **Early release:** ch1 owns the grant and its req drops after 2 pops while ch2 requests.
   - ch1 is released with `last_id`=1, one bubble, then ch2 is granted.
   - Output shows C1_xxxx×2 then C2_xxxx.
5. **Reset mid-burst:** `rstn_i` low during the 2nd pop of a ch2 burst.
   - `mcdt_val_o`/`mcdt_data_o`/`mcdt_id_o` go 0 asynchronously.
   - After release with all requesting, the first output id is 0.
6. **Wrap-around:** only ch2 then ch0 requesting, BURST_MAX=1.
   - Ids alternate 2,0,2,0 with one bubble each.
   - Pick logic wraps correctly from 2 to 0.

Source files
------------

// File: rtl/mcdt_pkg.sv
// -----------------------------------------------------------------------------
// mcdt_pkg
// Shared types and constants for the MCDT output-port arbitration logic.
//   mcdt_arb_state_e : arbiter FSM states (IDLE, XFER)
//   MCDT_NCH         : number of channels sharing the output port
//   MCDT_ID_W        : width of a channel id
//   mcdt_next_id()   : cyclic successor of a channel id (2 wraps to 0)
// -----------------------------------------------------------------------------
package mcdt_pkg;

  localparam int MCDT_NCH  = 3;
  localparam int MCDT_ID_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } mcdt_arb_state_e;

  // Any id at or above the last channel wraps to 0, so an out-of-range id
  // can never select a channel that does not exist.
  function automatic logic [MCDT_ID_W-1:0] mcdt_next_id(input logic [MCDT_ID_W-1:0] id);
    return (id >= MCDT_ID_W'(MCDT_NCH - 1)) ? '0 : id + MCDT_ID_W'(1);
  endfunction

endpackage

// File: rtl/mcdt_rr_pick.sv
// -----------------------------------------------------------------------------
// mcdt_rr_pick
// Combinational round-robin picker. Scans the eligible mask in cyclic order
// starting at i_last_id+1 and returns the first eligible channel.
// Ports:
//   i_elig    [MCDT_NCH-1:0]  : per-channel eligible mask
//   i_last_id [MCDT_ID_W-1:0] : previously granted channel
//   o_found                   : at least one channel is eligible
//   o_next_id [MCDT_ID_W-1:0] : winning channel (0 when nothing is eligible)
// -----------------------------------------------------------------------------
module mcdt_rr_pick
  import mcdt_pkg::*;
(
  input  logic [MCDT_NCH-1:0]  i_elig,
  input  logic [MCDT_ID_W-1:0] i_last_id,
  output logic                 o_found,
  output logic [MCDT_ID_W-1:0] o_next_id
);

  logic [MCDT_ID_W-1:0] w_cand;

  // Walk the ring once; the first hit sticks, later hits are ignored.
  always_comb begin
    o_found   = 1'b0;
    o_next_id = '0;
    w_cand    = i_last_id;
    for (int k = 0; k < MCDT_NCH; k++) begin
      w_cand = mcdt_next_id(w_cand);
      if (!o_found && i_elig[w_cand]) begin
        o_found   = 1'b1;
        o_next_id = w_cand;
      end
    end
  end

endmodule

// File: rtl/mcdt_arbiter.sv
// -----------------------------------------------------------------------------
// mcdt_arbiter
// Round-robin burst arbiter sharing the MCDT output port among three channel
// FIFOs. A grant is taken in IDLE, then up to BURST_MAX words are popped (one
// per cycle) in XFER; every grant change costs one IDLE bubble.
//
// Handshake: chN_req_i is the FIFO's valid (head word on chN_data_i is valid
// while it is high); chN_pop_o is the combinational accept, and the word is
// consumed at the clock edge where req and pop are both high. mcdt_val_o marks
// a registered word on mcdt_data_o/mcdt_id_o for exactly one cycle; the
// downstream stage has no backpressure.
//
// Ports:
//   clk_i, rstn_i                 : clock, asynchronous active-low reset
//   ch0..2_req_i                  : channel FIFO non-empty
//   ch0..2_data_i [DW-1:0]        : channel FIFO head word
//   arb_en_i      [2:0]           : per-channel enable mask
//   ch0..2_pop_o                  : combinational pop to each FIFO
//   mcdt_data_o   [DW-1:0]        : registered output word (0 when idle)
//   mcdt_val_o                    : registered output valid
//   mcdt_id_o     [1:0]           : registered source channel (held when idle)
// -----------------------------------------------------------------------------
module mcdt_arbiter
  import mcdt_pkg::*;
#(
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 ch0_req_i,
  input  logic                 ch1_req_i,
  input  logic                 ch2_req_i,
  input  logic [DW-1:0]        ch0_data_i,
  input  logic [DW-1:0]        ch1_data_i,
  input  logic [DW-1:0]        ch2_data_i,
  input  logic [MCDT_NCH-1:0]  arb_en_i,
  output logic                 ch0_pop_o,
  output logic                 ch1_pop_o,
  output logic                 ch2_pop_o,
  output logic [DW-1:0]        mcdt_data_o,
  output logic                 mcdt_val_o,
  output logic [MCDT_ID_W-1:0] mcdt_id_o
);

  localparam int CNT_W = $clog2(BURST_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  // All FSM state in one struct so it can be probed as a unit.
  typedef struct packed {
    mcdt_arb_state_e      state;
    logic [MCDT_ID_W-1:0] owner;
    logic [MCDT_ID_W-1:0] last_id;
    logic [CNT_W-1:0]     cnt;
  } arb_ctl_t;

  arb_ctl_t             r_ctl;
  logic [DW-1:0]        r_data;
  logic                 r_val;
  logic [MCDT_ID_W-1:0] r_id;

  logic [MCDT_NCH-1:0]  w_elig;
  logic [MCDT_NCH-1:0]  w_pop;
  logic                 w_pop_any;
  logic                 w_xfer;
  logic                 w_found;
  logic [MCDT_ID_W-1:0] w_next_id;
  logic [DW-1:0]        w_head;

  assign w_elig = {ch2_req_i, ch1_req_i, ch0_req_i} & arb_en_i;
  assign w_xfer = (r_ctl.state == XFER);

  // Only the owner can pop, so at most one pop bit is ever set.
  always_comb begin
    w_pop = '0;
    for (int n = 0; n < MCDT_NCH; n++) begin
      w_pop[n] = w_xfer && (r_ctl.owner == MCDT_ID_W'(n)) && w_elig[n];
    end
  end

  assign w_pop_any = |w_pop;

  always_comb begin
    case (r_ctl.owner)
      2'd0:    w_head = ch0_data_i;
      2'd1:    w_head = ch1_data_i;
      default: w_head = ch2_data_i;
    endcase
  end

  mcdt_rr_pick u_pick (
    .i_elig    (w_elig),
    .i_last_id (r_ctl.last_id),
    .o_found   (w_found),
    .o_next_id (w_next_id)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ctl.state   <= IDLE;
      r_ctl.owner   <= '0;
      r_ctl.last_id <= MCDT_ID_W'(MCDT_NCH - 1);  // ch0 wins the first pick
      r_ctl.cnt     <= '0;
      r_data        <= '0;
      r_val         <= 1'b0;
      r_id          <= '0;
    end else begin
      // Output stage: a word only on a pop cycle, zero otherwise; id holds.
      r_val  <= w_pop_any;
      r_data <= w_pop_any ? w_head : '0;
      if (w_pop_any) begin
        r_id <= r_ctl.owner;
      end

      case (r_ctl.state)
        IDLE: begin
          if (w_found) begin
            r_ctl.owner <= w_next_id;
            r_ctl.cnt   <= '0;
            r_ctl.state <= XFER;
          end
        end
        XFER: begin
          if (w_pop_any) begin
            r_ctl.cnt <= r_ctl.cnt + CNT_W'(1);
            // A full burst always releases, even if the owner still has data.
            if (r_ctl.cnt == CNT_LAST) begin
              r_ctl.last_id <= r_ctl.owner;
              r_ctl.state   <= IDLE;
            end
          end else begin
            // Owner ran dry or was disabled: release in this same cycle.
            r_ctl.last_id <= r_ctl.owner;
            r_ctl.state   <= IDLE;
          end
        end
        default: r_ctl.state <= IDLE;
      endcase
    end
  end

  assign ch0_pop_o   = w_pop[0];
  assign ch1_pop_o   = w_pop[1];
  assign ch2_pop_o   = w_pop[2];
  assign mcdt_data_o = r_data;
  assign mcdt_val_o  = r_val;
  assign mcdt_id_o   = r_id;

endmodule
